// File: rtl/xrs_pkg.sv
// Shared constants and types for the register-file writeback block.
package xrs_pkg;
   localparam int XLEN = 64;
   localparam int AW   = 5;

   // Register 0 is hardwired to zero and never written.
   localparam logic [AW-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic [AW-1:0]   rd;
      logic [XLEN-1:0] dat;
   } wb_req_t;
endpackage

// File: rtl/xrs_writeback_if.sv
// Bundle of write-request, register-file write-port and read-bypass signals.
interface xrs_writeback_if;
   import xrs_pkg::*;

   logic            alu_valid_i;
   logic            alu_ready_o;
   logic [AW-1:0]   alu_rd_i;
   logic [XLEN-1:0] alu_dat_i;
   logic            ld_valid_i;
   logic [AW-1:0]   ld_rd_i;
   logic [XLEN-1:0] ld_dat_i;
   logic [AW-1:0]   rd_o;
   logic [XLEN-1:0] rdat_o;
   logic            rwe_o;
   logic [AW-1:0]   ra_i;
   logic [AW-1:0]   rb_i;
   logic [XLEN-1:0] raw_a_i;
   logic [XLEN-1:0] raw_b_i;
   logic [XLEN-1:0] rdata_o;
   logic [XLEN-1:0] rdatb_o;
   logic            busy_o;

   // CPU side: drives requests and read addresses, consumes the write port.
   modport master (
      output alu_valid_i, alu_rd_i, alu_dat_i, ld_valid_i, ld_rd_i, ld_dat_i,
             ra_i, rb_i, raw_a_i, raw_b_i,
      input  alu_ready_o, rd_o, rdat_o, rwe_o, rdata_o, rdatb_o, busy_o
   );

   // Writeback block side.
   modport slave (
      input  alu_valid_i, alu_rd_i, alu_dat_i, ld_valid_i, ld_rd_i, ld_dat_i,
             ra_i, rb_i, raw_a_i, raw_b_i,
      output alu_ready_o, rd_o, rdat_o, rwe_o, rdata_o, rdatb_o, busy_o
   );
endinterface

// File: rtl/xrs_wb_bypass.sv
// One read-port bypass: remembers a same-cycle write to the read address
// and substitutes its data for the stale register-file output next cycle.
module xrs_wb_bypass
   import xrs_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            rwe_i,
   input  logic [AW-1:0]   rd_i,
   input  logic [XLEN-1:0] rdat_i,
   input  logic [AW-1:0]   raddr_i,
   input  logic [XLEN-1:0] raw_i,
   output logic [XLEN-1:0] rdata_o
);
   logic            hit_q;
   logic [XLEN-1:0] dat_q;

   // Capture the collision flag and the data being written alongside the read.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hit_q <= 1'b0;
         dat_q <= '0;
      end else begin
         hit_q <= rwe_i & (rd_i == raddr_i) & (raddr_i != REG_ZERO);
         dat_q <= rdat_i;
      end
   end

   // Newest value wins: captured write data over the synchronous read result.
   always_comb begin
      rdata_o = hit_q ? dat_q : raw_i;
   end
endmodule

// File: rtl/xrs_writeback.sv
// Register-file writeback: arbitrates load and ALU writes into a single
// registered write port and bypasses read/write collisions.
// Optional skid buffer for a stalled ALU result: define XRS_WB_SKID_EN.
module xrs_writeback
   import xrs_pkg::*;
(
   input  logic          clk_i,
   input  logic          rst_ni,
   xrs_writeback_if.slave bus
);
   localparam int NUM_PORTS = 2;

   wb_req_t ld_req, alu_req, sel_req;
   logic    accept;
   logic    skid_full;

   assign ld_req  = '{rd: bus.ld_rd_i,  dat: bus.ld_dat_i};
   assign alu_req = '{rd: bus.alu_rd_i, dat: bus.alu_dat_i};

`ifdef XRS_WB_SKID_EN
   wb_req_t skid_q;
   logic    skid_full_q;
   logic    alu_hs;

   assign skid_full       = skid_full_q;
   assign bus.alu_ready_o = ~skid_full_q;
   assign alu_hs          = bus.alu_valid_i & ~skid_full_q;

   // Park an ALU result that lost to a load; release it on the first load-free cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         skid_full_q <= 1'b0;
         skid_q      <= '0;
      end else if (bus.ld_valid_i && alu_hs) begin
         skid_full_q <= 1'b1;
         skid_q      <= alu_req;
      end else if (!bus.ld_valid_i && skid_full_q) begin
         skid_full_q <= 1'b0;
      end
   end

   // Fixed priority: load, then held skid entry, then a live ALU handshake.
   always_comb begin
      accept  = 1'b0;
      sel_req = '0;
      if (bus.ld_valid_i) begin
         accept  = 1'b1;
         sel_req = ld_req;
      end else if (skid_full_q) begin
         accept  = 1'b1;
         sel_req = skid_q;
      end else if (alu_hs) begin
         accept  = 1'b1;
         sel_req = alu_req;
      end
   end
`else
   assign skid_full       = 1'b0;
   assign bus.alu_ready_o = ~bus.ld_valid_i;

   // The load unit cannot stall, so it always wins; the ALU waits via ready.
   always_comb begin
      accept  = 1'b0;
      sel_req = '0;
      if (bus.ld_valid_i) begin
         accept  = 1'b1;
         sel_req = ld_req;
      end else if (bus.alu_valid_i) begin
         accept  = 1'b1;
         sel_req = alu_req;
      end
   end
`endif

   logic            rwe_q;
   logic [AW-1:0]   rd_q;
   logic [XLEN-1:0] rdat_q;

   // Registered write stage; writes to r0 are swallowed and leave rd/rdat untouched.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rwe_q  <= 1'b0;
         rd_q   <= '0;
         rdat_q <= '0;
      end else begin
         rwe_q <= accept && (sel_req.rd != REG_ZERO);
         if (accept && (sel_req.rd != REG_ZERO)) begin
            rd_q   <= sel_req.rd;
            rdat_q <= sel_req.dat;
         end
      end
   end

   assign bus.rwe_o  = rwe_q;
   assign bus.rd_o   = rd_q;
   assign bus.rdat_o = rdat_q;
   assign bus.busy_o = rwe_q | skid_full;

   logic [NUM_PORTS-1:0][AW-1:0]   raddr;
   logic [NUM_PORTS-1:0][XLEN-1:0] raw;
   logic [NUM_PORTS-1:0][XLEN-1:0] byp;

   assign raddr = {bus.rb_i, bus.ra_i};
   assign raw   = {bus.raw_b_i, bus.raw_a_i};

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_byp
      xrs_wb_bypass u_byp (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .rwe_i   (rwe_q),
         .rd_i    (rd_q),
         .rdat_i  (rdat_q),
         .raddr_i (raddr[p]),
         .raw_i   (raw[p]),
         .rdata_o (byp[p])
      );
   end

   assign bus.rdata_o = byp[0];
   assign bus.rdatb_o = byp[1];
endmodule

// File: tb/tb_xrs_writeback.sv
// Directed bench for xrs_writeback; covers both builds of XRS_WB_SKID_EN.
module tb_xrs_writeback;
   import xrs_pkg::*;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   xrs_writeback_if wb_if ();

   xrs_writeback dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (wb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one cycle and settle just past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wb_if.alu_valid_i = 1'b0;
      wb_if.alu_rd_i    = '0;
      wb_if.alu_dat_i   = '0;
      wb_if.ld_valid_i  = 1'b0;
      wb_if.ld_rd_i     = '0;
      wb_if.ld_dat_i    = '0;
      wb_if.ra_i        = '0;
      wb_if.rb_i        = '0;
      wb_if.raw_a_i     = '0;
      wb_if.raw_b_i     = '0;
   endtask

   task automatic alu(input logic [AW-1:0] rd, input logic [XLEN-1:0] dat);
      wb_if.alu_valid_i = 1'b1;
      wb_if.alu_rd_i    = rd;
      wb_if.alu_dat_i   = dat;
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      wb_if.raw_a_i = 64'h55;
      wb_if.raw_b_i = 64'h66;
      #12;
      chk("rst_rwe",   wb_if.rwe_o,   0);
      chk("rst_rd",    wb_if.rd_o,    0);
      chk("rst_rdat",  wb_if.rdat_o,  0);
      chk("rst_busy",  wb_if.busy_o,  0);
      chk("rst_rdata", wb_if.rdata_o, 64'h55);
      chk("rst_rdatb", wb_if.rdatb_o, 64'h66);
      chk("rst_ready", wb_if.alu_ready_o, 1);
      rst_n = 1'b1;
      idle_inputs();
      step();

      // ALU only
      alu(5'd5, 64'h1122334455667788);
      #1 chk("alu_ready", wb_if.alu_ready_o, 1);
      step();
      chk("alu_rwe",  wb_if.rwe_o,  1);
      chk("alu_rd",   wb_if.rd_o,   5);
      chk("alu_rdat", wb_if.rdat_o, 64'h1122334455667788);
      chk("alu_busy", wb_if.busy_o, 1);
      wb_if.alu_valid_i = 1'b0;
      step();
      chk("alu_rwe_off", wb_if.rwe_o, 0);
      chk("alu_rd_hold", wb_if.rd_o,  5);

      // Collision: load rd7/0xAA vs ALU rd9/0xBB
      wb_if.ld_valid_i = 1'b1;
      wb_if.ld_rd_i    = 5'd7;
      wb_if.ld_dat_i   = 64'hAA;
      alu(5'd9, 64'hBB);
`ifdef XRS_WB_SKID_EN
      #1 chk("col_ready0", wb_if.alu_ready_o, 1);
      step();
      chk("col_rwe0",   wb_if.rwe_o,  1);
      chk("col_rd0",    wb_if.rd_o,   7);
      chk("col_rdat0",  wb_if.rdat_o, 64'hAA);
      chk("col_ready1", wb_if.alu_ready_o, 0);
      chk("col_busy1",  wb_if.busy_o, 1);
      wb_if.ld_valid_i  = 1'b0;
      wb_if.alu_valid_i = 1'b0;
      step();
      chk("col_rwe1",   wb_if.rwe_o,  1);
      chk("col_rd1",    wb_if.rd_o,   9);
      chk("col_rdat1",  wb_if.rdat_o, 64'hBB);
      chk("col_ready2", wb_if.alu_ready_o, 1);
`else
      #1 chk("col_ready0", wb_if.alu_ready_o, 0);
      step();
      chk("col_rwe0",   wb_if.rwe_o,  1);
      chk("col_rd0",    wb_if.rd_o,   7);
      chk("col_rdat0",  wb_if.rdat_o, 64'hAA);
      wb_if.ld_valid_i = 1'b0;
      #1 chk("col_ready1", wb_if.alu_ready_o, 1);
      step();
      chk("col_rwe1",   wb_if.rwe_o,  1);
      chk("col_rd1",    wb_if.rd_o,   9);
      chk("col_rdat1",  wb_if.rdat_o, 64'hBB);
      wb_if.alu_valid_i = 1'b0;
`endif
      step();
      chk("col_rwe_off", wb_if.rwe_o, 0);

      // Write to r0 is consumed without touching the write port
      alu(5'd0, 64'hFF);
      #1 chk("r0_ready", wb_if.alu_ready_o, 1);
      step();
      wb_if.alu_valid_i = 1'b0;
      chk("r0_rwe",  wb_if.rwe_o,  0);
      chk("r0_rd",   wb_if.rd_o,   9);
      chk("r0_rdat", wb_if.rdat_o, 64'hBB);

      // Bypass hit on A, miss on B
      alu(5'd3, 64'hDEAD);
      step();
      wb_if.alu_valid_i = 1'b0;
      wb_if.ra_i = 5'd3;
      wb_if.rb_i = 5'd4;
      step();
      wb_if.raw_a_i = 64'h0;
      wb_if.raw_b_i = 64'h44;
      #1;
      chk("byp_a_hit",  wb_if.rdata_o, 64'hDEAD);
      chk("byp_b_miss", wb_if.rdatb_o, 64'h44);

      // ra=0 never bypasses; B now hits
      alu(5'd3, 64'hBEEF);
      step();
      wb_if.alu_valid_i = 1'b0;
      wb_if.ra_i = 5'd0;
      wb_if.rb_i = 5'd3;
      step();
      wb_if.raw_a_i = 64'h77;
      wb_if.raw_b_i = 64'h88;
      #1;
      chk("byp_a_zero", wb_if.rdata_o, 64'h77);
      chk("byp_b_hit",  wb_if.rdatb_o, 64'hBEEF);
      step();
      chk("byp_b_expire", wb_if.rdatb_o, 64'h88);

      // Back-to-back ALU writes r1..r8
      for (int i = 1; i <= 8; i++) begin
         alu(5'(i), 64'(i) * 64'h1111);
         step();
         chk($sformatf("b2b_rwe%0d", i),  wb_if.rwe_o,  1);
         chk($sformatf("b2b_rd%0d", i),   wb_if.rd_o,   64'(i));
         chk($sformatf("b2b_rdat%0d", i), wb_if.rdat_o, 64'(i) * 64'h1111);
      end
      wb_if.alu_valid_i = 1'b0;
      step();
      chk("b2b_rwe_off", wb_if.rwe_o, 0);

      // Reset mid-operation with a live hit flag (and a held skid entry if built)
      wb_if.ra_i = 5'd10;
      wb_if.rb_i = 5'd0;
      alu(5'd10, 64'hCAFE);
      step();
      wb_if.ld_valid_i = 1'b1;
      wb_if.ld_rd_i    = 5'd12;
      wb_if.ld_dat_i   = 64'h1212;
      alu(5'd11, 64'h1111);
      step();
      wb_if.raw_a_i = 64'h99;
      #1;
      chk("mid_rwe_pre",  wb_if.rwe_o,   1);
      chk("mid_rd_pre",   wb_if.rd_o,    12);
      chk("mid_byp_pre",  wb_if.rdata_o, 64'hCAFE);
`ifdef XRS_WB_SKID_EN
      chk("mid_ready_pre", wb_if.alu_ready_o, 0);
`endif
      rst_n = 1'b0;
      #1;
      chk("mid_rwe",   wb_if.rwe_o,   0);
      chk("mid_busy",  wb_if.busy_o,  0);
      chk("mid_rd",    wb_if.rd_o,    0);
      chk("mid_rdata", wb_if.rdata_o, 64'h99);
      idle_inputs();
      #1;
      chk("mid_ready", wb_if.alu_ready_o, 1);
      rst_n = 1'b1;
      step();
      chk("post_idle_rwe", wb_if.rwe_o, 0);
      alu(5'd13, 64'h1313);
      step();
      wb_if.alu_valid_i = 1'b0;
      chk("post_rwe",  wb_if.rwe_o,  1);
      chk("post_rd",   wb_if.rd_o,   13);
      chk("post_rdat", wb_if.rdat_o, 64'h1313);
      step();
      chk("post_rwe_off", wb_if.rwe_o,  0);
      chk("post_busy",    wb_if.busy_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/xrs_writeback.md
Name: xrs_writeback

Overview:
- Write-side companion to the 31x64 register file (synchronous read, one write port).
- Arbitrates register writes from the ALU retire path and the load unit, and drives the register file's rd/rdat/rwe write port through a one-cycle registered stage.
- Corrects the register file's synchronous read outputs when a read and a write hit the same address in the same cycle, so the CPU always sees the newest value.

Parameters:
- XLEN, 64, data width of register values.
- AW, 5, register address width (32 addresses; address 0 hardwired to zero).

Ports:
- clk_i  in  1  processor clock.
- rst_ni  in  1  asynchronous active-low reset.
- alu_valid_i  in  1  ALU result valid.
- alu_ready_o  out  1  ALU result accepted when high together with alu_valid_i.
- alu_rd_i  in  AW  ALU destination register.
- alu_dat_i  in  XLEN  ALU result.
- ld_valid_i  in  1  load data valid; the load unit cannot stall, so there is no ready signal.
- ld_rd_i  in  AW  load destination register.
- ld_dat_i  in  XLEN  load data.
- rd_o  out  AW  register-file write address.
- rdat_o  out  XLEN  register-file write data.
- rwe_o  out  1  register-file write enable.
- ra_i  in  AW  read address A presented to the register file this cycle.
- rb_i  in  AW  read address B presented to the register file this cycle.
- raw_a_i  in  XLEN  register-file port A output (valid the cycle after ra_i).
- raw_b_i  in  XLEN  register-file port B output.
- rdata_o  out  XLEN  bypass-corrected port A data.
- rdatb_o  out  XLEN  bypass-corrected port B data.
- busy_o  out  1  a write is in flight (rwe_o or a held ALU entry).

Behaviour:
- Reset (rst_ni low, asynchronous) sets:
  - rwe_o=0, rd_o=0, rdat_o=0, busy_o=0;
  - bypass hit flags=0, captured data=0;
  - skid buffer empty.
- All state updates on the rising edge of clk_i.
- Arbitration, one accept per cycle:
  - Priority order: ld_valid_i first, then the skid entry (feature only), then the ALU handshake.
  - An accepted request appears at the next edge as rwe_o=1 with rd_o/rdat_o. Latency is exactly 1 cycle.
  - A request with rd==0 is accepted and consumed, but rwe_o stays 0 and rd_o/rdat_o hold their previous values.
  - No accept in a cycle: rwe_o=0 the next cycle.
  - Ordering is not enforced across sources. Upstream guarantees that no two un-retired writes target the same rd.
- Bypass, per port (A shown; B is identical):
  - At an edge, capture hit_a = rwe_o & (rd_o==ra_i) & (ra_i!=0), and dat_a = rdat_o.
  - The following cycle: rdata_o = hit_a ? dat_a : raw_a_i. This output is combinational from the registered flags.
  - Reset mid-operation clears the hit flags, so rdata_o equals raw_a_i immediately.
- busy_o = rwe_o | skid_full.

Optional Feature:
- Macro: XRS_WB_SKID_EN.
- Without the macro:
  - alu_ready_o = ~ld_valid_i, combinational.
  - No skid state.
- With the macro:
  - alu_ready_o = ~skid_full, registered; it reads 1 out of reset.
  - ALU handshake while ld_valid_i is high: the ALU request loads the skid entry, and alu_ready_o falls the next cycle.
  - The skid entry drains in the first cycle with ld_valid_i low. While it drains, no new ALU request is accepted (ready is low).
  - Reset discards a held entry.

Decomposition:
- Package xrs_pkg:
  - XLEN and AW constants;
  - typedef wb_req_t {rd[AW], dat[XLEN]};
  - constant REG_ZERO=0.
- Sub-module xrs_wb_bypass: hit capture plus output mux, instantiated twice (ports A and B).

Test Plan:
- ALU only: alu_valid_i=1, alu_rd_i=5, alu_dat_i=0x1122334455667788 -> next cycle rwe_o=1, rd_o=5, rdat_o=0x1122334455667788; the cycle after, rwe_o=0.
- Collision, both sources valid, load rd=7 dat=0xAA, ALU rd=9 dat=0xBB:
  - Without skid: alu_ready_o=0, write 7/0xAA; the ALU write lands when ld_valid_i drops.
  - With skid: ALU accepted, 7/0xAA written, then 9/0xBB the next cycle, and alu_ready_o is low for exactly one cycle.
- rd=0 write (ALU rd=0, dat=0xFF) -> handshake completes, rwe_o stays 0 and rd_o/rdat_o unchanged.
- Bypass:
  - rwe_o=1, rd_o=3, rdat_o=0xDEAD while ra_i=3, rb_i=4; raw_a_i=0x0 (stale) and raw_b_i=0x44 next cycle -> rdata_o=0xDEAD, rdatb_o=0x44.
  - Repeat with ra_i=0 -> rdata_o=raw_a_i.
- Reset mid-operation: assert rst_ni=0 asynchronously while rwe_o=1 and skid full -> rwe_o=0, busy_o=0 and hit flags clear immediately, without waiting for a clock edge; after release, the first accepted write behaves normally.
- Back-to-back: ALU writes r1..r8 on consecutive cycles with ld_valid_i=0 -> eight consecutive rwe_o pulses, in order, with matching data.
